// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the DDR frame DMA controllers.
// Holds the burst and beat geometry, the DDR offset and frame-index widths,
// the controller FSM encoding, and a helper that turns a frame size in bytes
// into the number of beats to transfer.
package ddr_ctrl_pkg;

  localparam int unsigned MAX_BURST      = 256;
  localparam int unsigned BYTES_PER_BEAT = 8;
  localparam int unsigned BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int unsigned OFFSET_W       = 20;
  localparam int unsigned IDX_W          = 2;
  localparam int unsigned BASE_W         = 32 - IDX_W - OFFSET_W;
  localparam int unsigned BURST_W        = $clog2(MAX_BURST) + 1;
  // Wide enough to hold the full 1 MiB frame expressed in beats.
  localparam int unsigned REM_W          = OFFSET_W - BEAT_SHIFT + 1;

  localparam logic [REM_W-1:0] MAX_FRAME_BEATS = REM_W'(1 << (OFFSET_W - BEAT_SHIFT));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_READ
  } state_t;

  // Round up to whole beats so a trailing partial beat is still fetched,
  // then clamp to the span addressable by the offset field.
  function automatic logic [REM_W-1:0] frame_beats(input logic [31:0] size_bytes);
    logic [32:0] beats;
    beats = ({1'b0, size_bytes} + 33'(BYTES_PER_BEAT - 1)) >> BEAT_SHIFT;
    if (beats > 33'(MAX_FRAME_BEATS)) begin
      return MAX_FRAME_BEATS;
    end
    return beats[REM_W-1:0];
  endfunction

endpackage

// File: rtl/ddr_read_controller_dec_sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// An edge on async_i appears as a one-cycle pulse_o three clocks later.
//   clk_i    : destination clock
//   reset_i  : asynchronous active-low reset
//   async_i  : level from a foreign clock domain (held >= 2 clk_i periods)
//   pulse_o  : single-cycle pulse on each rising edge of async_i
module sync_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ddr_read_controller_dec.sv
// Frame-based DDR read DMA for the decoder/display path.
// On each accepted start-of-frame the selected frame buffer is read from DDR
// through the arbiter in bursts of up to 256 beats (8 bytes each) and the
// returned beats are pushed into the display line FIFO.
//   wrclk_i / wrclk_reset_i   : clock and async active-low reset
//   decoder_en_i              : quasi-static enable
//   sof_i                     : asynchronous start-of-frame level pulse
//   frame_ddr_addr_i          : frame buffer base, address bits 31:22
//   frame_idx_i, frame_size_i : frame selection, latched at accepted SOF
//   fifo_count_i              : line FIFO fill level in beats
//   fifo_reset_o, fifo_write_o: line FIFO reset (active-low) and write enable
//   read_*                    : arbiter read request/ack/data-valid/done
//   frame_done_o, busy_o      : frame completion pulse and activity flag
module ddr_read_controller_dec
  import ddr_ctrl_pkg::*;
#(
  parameter int g_DDR_AXI_AWIDTH = 32,
  parameter int g_FIFO_DEPTH     = 2048
) (
  input  logic                        wrclk_i,
  input  logic                        wrclk_reset_i,
  input  logic                        decoder_en_i,
  input  logic                        sof_i,
  input  logic [BASE_W-1:0]           frame_ddr_addr_i,
  input  logic [IDX_W-1:0]            frame_idx_i,
  input  logic [31:0]                 frame_size_i,
  input  logic [11:0]                 fifo_count_i,
  output logic                        fifo_reset_o,
  output logic                        fifo_write_o,
  output logic                        read_req_o,
  input  logic                        read_ackn_i,
  input  logic                        read_valid_i,
  input  logic                        read_done_i,
  output logic [g_DDR_AXI_AWIDTH-1:0] read_start_addr_o,
  output logic [7:0]                  read_length_o,
  output logic                        frame_done_o,
  output logic                        busy_o
);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [OFFSET_W-1:0]         offset_q, offset_d;
  logic [REM_W-1:0]            remaining_q, remaining_d;
  logic [BURST_W-1:0]          burst_q, burst_d;
  logic [BURST_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic                        sof_pending_q, sof_pending_d;
  logic                        fifo_rst_n_q, fifo_rst_n_d;
  logic [g_DDR_AXI_AWIDTH-1:0] addr_q, addr_d;
  logic [7:0]                  len_q, len_d;

  logic                        sof_pulse;
  logic                        sof_acc;
  logic [BURST_W-1:0]          burst_next;
  logic                        fifo_fits;
  logic                        beat_room;
  logic                        restart;
  logic                        frame_done_c;

  sync_edge_det u_sof_sync (
    .clk_i   (wrclk_i),
    .reset_i (wrclk_reset_i),
    .async_i (sof_i),
    .pulse_o (sof_pulse)
  );

  assign sof_acc    = sof_pulse & decoder_en_i;
  assign burst_next = (remaining_q >= REM_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                         : remaining_q[BURST_W-1:0];
  // Compare fill + burst against depth so a count above depth never wraps.
  assign fifo_fits  = ({1'b0, fifo_count_i} + 13'(burst_next)) <= 13'(g_FIFO_DEPTH);
  assign beat_room  = beat_cnt_q < burst_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    offset_d      = offset_q;
    remaining_d   = remaining_q;
    burst_d       = burst_q;
    beat_cnt_d    = beat_cnt_q;
    sof_pending_d = sof_pending_q;
    addr_d        = addr_q;
    len_d         = len_q;
    restart       = 1'b0;
    frame_done_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sof_acc) restart = 1'b1;
      end
      ST_CHECK: begin
        if (!decoder_en_i) begin
          state_d       = ST_IDLE;
          sof_pending_d = 1'b0;
        end else if (sof_acc) begin
          restart = 1'b1;
        end else if (remaining_q == '0) begin
          frame_done_c = 1'b1;
          state_d      = ST_IDLE;
        end else if (fifo_fits) begin
          burst_d = burst_next;
          addr_d  = g_DDR_AXI_AWIDTH'({frame_ddr_addr_i, idx_q, offset_q});
          len_d   = 8'(burst_next - BURST_W'(1));
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A burst in flight cannot be aborted, so a new frame waits for it.
        if (sof_acc) sof_pending_d = 1'b1;
        if (read_ackn_i) begin
          beat_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (sof_acc) sof_pending_d = 1'b1;
        if (read_valid_i && beat_room) beat_cnt_d = beat_cnt_q + BURST_W'(1);
        if (read_done_i) begin
          if ((sof_pending_q || sof_acc) && decoder_en_i) begin
            restart = 1'b1;
          end else if (!decoder_en_i) begin
            sof_pending_d = 1'b0;
            state_d       = ST_IDLE;
          end else begin
            offset_d    = offset_q + (OFFSET_W'(burst_q) << BEAT_SHIFT);
            remaining_d = remaining_q - REM_W'(burst_q);
            state_d     = ST_CHECK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      idx_d         = frame_idx_i;
      offset_d      = '0;
      remaining_d   = frame_beats(frame_size_i);
      sof_pending_d = 1'b0;
      state_d       = ST_CHECK;
    end

    // FIFO is flushed for one cycle per new frame and held while disabled and idle.
    fifo_rst_n_d = ~(restart | (~decoder_en_i & (state_d == ST_IDLE)));
  end

  always_ff @(posedge wrclk_i or negedge wrclk_reset_i) begin
    if (!wrclk_reset_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      offset_q      <= '0;
      remaining_q   <= '0;
      burst_q       <= '0;
      beat_cnt_q    <= '0;
      sof_pending_q <= 1'b0;
      fifo_rst_n_q  <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      offset_q      <= offset_d;
      remaining_q   <= remaining_d;
      burst_q       <= burst_d;
      beat_cnt_q    <= beat_cnt_d;
      sof_pending_q <= sof_pending_d;
      fifo_rst_n_q  <= fifo_rst_n_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
    end
  end

  // Request drops combinationally in the acknowledge cycle.
  assign read_req_o        = (state_q == ST_REQ) & ~read_ackn_i;
  // Beats beyond the requested burst length are discarded.
  assign fifo_write_o      = (state_q == ST_READ) & read_valid_i & beat_room;
  assign fifo_reset_o      = fifo_rst_n_q;
  assign read_start_addr_o = addr_q;
  assign read_length_o     = len_q;
  assign frame_done_o      = frame_done_c;
  assign busy_o            = state_q != ST_IDLE;

endmodule

// File: tb/tb_ddr_read_controller_dec.sv
`timescale 1ns/1ps
module tb_ddr_read_controller_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sof;
  logic [9:0]  base;
  logic [1:0]  idx;
  logic [31:0] fsize;
  logic [11:0] fcount;
  logic        fifo_reset_o, fifo_write_o, read_req_o, frame_done_o, busy_o;
  logic        read_ackn, read_valid, read_done;
  logic [31:0] read_start_addr_o;
  logic [7:0]  read_length_o;

  always #5 clk = ~clk;

  ddr_read_controller_dec #(.g_DDR_AXI_AWIDTH(32), .g_FIFO_DEPTH(2048)) dut (
    .wrclk_i           (clk),
    .wrclk_reset_i     (rst_n),
    .decoder_en_i      (en),
    .sof_i             (sof),
    .frame_ddr_addr_i  (base),
    .frame_idx_i       (idx),
    .frame_size_i      (fsize),
    .fifo_count_i      (fcount),
    .fifo_reset_o      (fifo_reset_o),
    .fifo_write_o      (fifo_write_o),
    .read_req_o        (read_req_o),
    .read_ackn_i       (read_ackn),
    .read_valid_i      (read_valid),
    .read_done_i       (read_done),
    .read_start_addr_o (read_start_addr_o),
    .read_length_o     (read_length_o),
    .frame_done_o      (frame_done_o),
    .busy_o            (busy_o)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Running event totals sampled mid-cycle; tests work on deltas.
  int wr_total = 0, done_total = 0, rstlo_total = 0, reqcyc_total = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_write_o)  wr_total++;
      if (frame_done_o)  done_total++;
      if (!fifo_reset_o) rstlo_total++;
      if (read_req_o)    reqcyc_total++;
    end
  end

  // Arbiter responder: acknowledges requests after a random delay, records
  // the burst parameters, streams burst+extra beats with random gaps, then done.
  logic        arb_hold = 1'b0;
  int          obs_n = 0;
  logic [31:0] obs_addr [0:63];
  logic [7:0]  obs_len  [0:63];
  initial begin : arbiter
    int          beats;
    int          wait_c;
    logic [7:0]  len_l;
    read_ackn  = 1'b0;
    read_valid = 1'b0;
    read_done  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && read_req_o) begin
        wait_c = $urandom_range(0, 2);
        repeat (wait_c) begin @(posedge clk); #1; end
        while (arb_hold && rst_n) begin @(posedge clk); #1; end
        if (rst_n) begin
          len_l = read_length_o;
          if (obs_n < 64) begin
            obs_addr[obs_n] = read_start_addr_o;
            obs_len[obs_n]  = len_l;
          end
          obs_n++;
          read_ackn = 1'b1;
          @(posedge clk); #1;
          read_ackn = 1'b0;
          beats = int'(len_l) + 1 + int'($urandom_range(0, 2));
          for (int i = 0; i < beats && rst_n; i++) begin
            if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
            read_valid = 1'b1;
            @(posedge clk); #1;
            read_valid = 1'b0;
          end
          if (rst_n) begin
            read_done = 1'b1;
            @(posedge clk); #1;
            read_done = 1'b0;
          end
        end
      end
    end
  end

  // Reference model: burst list derived directly from frame geometry.
  logic [31:0] exp_addr [$];
  logic [7:0]  exp_len  [$];
  int          exp_beats;
  task automatic build_model(input logic [31:0] size, input logic [1:0] fidx, input logic [9:0] fbase);
    longint beats, off, b;
    exp_addr.delete();
    exp_len.delete();
    beats = (longint'(size) + 7) / 8;
    if (beats > 131072) beats = 131072;
    exp_beats = int'(beats);
    off = 0;
    while (beats > 0) begin
      b = (beats > 256) ? 256 : beats;
      exp_addr.push_back({fbase, fidx, 20'(off)});
      exp_len.push_back(8'(b - 1));
      off = (off + b * 8) % (longint'(1) << 20);
      beats -= b;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_sof();
    sof = 1'b1;
    tick(3);
    sof = 1'b0;
    tick(2);
  endtask

  task automatic wait_idle(input int max_c, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_c; i++) begin
      @(negedge clk);
      if (!busy_o) begin timed_out = 1'b0; break; end
    end
    tick(3);
  endtask

  task automatic wait_valid(input int max_c, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_c; i++) begin
      @(negedge clk);
      if (read_valid) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; sof = 1'b0; base = 10'h3; idx = 2'd0;
    fsize = 32'd0; fcount = 12'd0;
    tick(3);
    chk_cnt++; if (fifo_reset_o !== 1'b0) $display("FAIL reset_fifo_reset: got %b expected 0", fifo_reset_o); else pass_cnt++;
    chk_cnt++; if (read_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", read_req_o); else pass_cnt++;
    chk_cnt++; if (fifo_write_o !== 1'b0) $display("FAIL reset_write: got %b expected 0", fifo_write_o); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
    chk_cnt++; if (read_start_addr_o !== 32'h0) $display("FAIL reset_addr: got %h expected 0", read_start_addr_o); else pass_cnt++;
    chk_cnt++; if (read_length_o !== 8'h0) $display("FAIL reset_len: got %h expected 0", read_length_o); else pass_cnt++;
    chk_cnt++; if (frame_done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", frame_done_o); else pass_cnt++;
    rst_n = 1'b1;
    tick(3);
    chk_cnt++; if (fifo_reset_o !== 1'b1) $display("FAIL post_reset_fifo_reset: got %b expected 1", fifo_reset_o); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_frames();
    int  obs0, wr0, done0, nb;
    bit  to;
    for (int s = 0; s < 8; s++) begin
      case (s)
        0: begin fsize = 32'd4096; idx = 2'd2; base = 10'h3;   fcount = 12'd0; end
        1: begin fsize = 32'd2100; idx = 2'd1; base = 10'h3;   fcount = 12'd0; end
        2: begin fsize = 32'd0;    idx = 2'd3; base = 10'h1FF; fcount = 12'd0; end
        3: begin fsize = 32'd7;    idx = 2'd0; base = 10'h2A5; fcount = 12'd100; end
        default: begin
          fsize  = $urandom_range(1, 3000);
          idx    = 2'($urandom_range(0, 3));
          base   = 10'($urandom_range(0, 1023));
          fcount = 12'($urandom_range(0, 1700));
        end
      endcase
      build_model(fsize, idx, base);
      obs0 = obs_n; wr0 = wr_total; done0 = done_total;
      send_sof();
      wait_idle(3000, to);
      nb = obs_n - obs0;
      chk_cnt++; if (to !== 1'b0) $display("FAIL frame%0d_timeout: busy never dropped", s); else pass_cnt++;
      chk_cnt++; if (nb !== exp_addr.size()) $display("FAIL frame%0d_bursts: got %0d expected %0d", s, nb, exp_addr.size()); else pass_cnt++;
      for (int b = 0; b < nb && b < exp_addr.size() && obs0 + b < 64; b++) begin
        chk_cnt++; if (obs_addr[obs0+b] !== exp_addr[b]) $display("FAIL frame%0d_addr%0d: got %h expected %h", s, b, obs_addr[obs0+b], exp_addr[b]); else pass_cnt++;
        chk_cnt++; if (obs_len[obs0+b] !== exp_len[b]) $display("FAIL frame%0d_len%0d: got %0d expected %0d", s, b, obs_len[obs0+b], exp_len[b]); else pass_cnt++;
      end
      chk_cnt++; if (wr_total - wr0 !== exp_beats) $display("FAIL frame%0d_writes: got %0d expected %0d", s, wr_total - wr0, exp_beats); else pass_cnt++;
      chk_cnt++; if (done_total - done0 !== 1) $display("FAIL frame%0d_done: got %0d expected 1", s, done_total - done0); else pass_cnt++;
      if (s == 0 && nb == 2 && obs0 + 1 < 64) begin
        chk_cnt++; if (obs_addr[obs0+1] !== 32'h00E00800) $display("FAIL basic_second_addr: got %h expected 00e00800", obs_addr[obs0+1]); else pass_cnt++;
      end
    end
    fcount = 12'd0;
  endtask

  task automatic test_backpressure();
    int  obs0, wr0, done0, req0;
    bit  to;
    fsize = 32'd4096; idx = 2'd1; base = 10'h155; fcount = 12'd1900;
    obs0 = obs_n; wr0 = wr_total; done0 = done_total; req0 = reqcyc_total;
    send_sof();
    tick(20);
    chk_cnt++; if (busy_o !== 1'b1) $display("FAIL bp_busy: got %b expected 1", busy_o); else pass_cnt++;
    chk_cnt++; if (reqcyc_total - req0 + obs_n - obs0 !== 0) $display("FAIL bp_no_req: got %0d request cycles expected 0", reqcyc_total - req0); else pass_cnt++;
    fcount = 12'd1792;
    tick(2);
    chk_cnt++; if ((reqcyc_total - req0 + obs_n - obs0 > 0) !== 1'b1) $display("FAIL bp_req_issued: got 0 requests expected at least 1"); else pass_cnt++;
    wait_idle(3000, to);
    chk_cnt++; if (to !== 1'b0) $display("FAIL bp_timeout: busy never dropped"); else pass_cnt++;
    chk_cnt++; if (obs_n - obs0 !== 2) $display("FAIL bp_bursts: got %0d expected 2", obs_n - obs0); else pass_cnt++;
    chk_cnt++; if (wr_total - wr0 !== 512) $display("FAIL bp_writes: got %0d expected 512", wr_total - wr0); else pass_cnt++;
    chk_cnt++; if (done_total - done0 !== 1) $display("FAIL bp_done: got %0d expected 1", done_total - done0); else pass_cnt++;
    fcount = 12'd0;
  endtask

  task automatic test_sof_mid_burst();
    int  obs0, wr0, done0, rst0;
    bit  to;
    fsize = 32'd4096; idx = 2'd1; base = 10'h2A;
    obs0 = obs_n; wr0 = wr_total; done0 = done_total;
    send_sof();
    wait_valid(200, to);
    chk_cnt++; if (to !== 1'b0) $display("FAIL mid_no_data: no read beat seen"); else pass_cnt++;
    rst0 = rstlo_total;
    idx = 2'd3; fsize = 32'd1024;
    send_sof();
    wait_idle(3000, to);
    chk_cnt++; if (to !== 1'b0) $display("FAIL mid_timeout: busy never dropped"); else pass_cnt++;
    chk_cnt++; if (obs_n - obs0 !== 2) $display("FAIL mid_bursts: got %0d expected 2", obs_n - obs0); else pass_cnt++;
    if (obs_n - obs0 == 2 && obs0 + 1 < 64) begin
      chk_cnt++; if (obs_addr[obs0] !== {10'h2A, 2'd1, 20'h0}) $display("FAIL mid_addr0: got %h expected %h", obs_addr[obs0], {10'h2A, 2'd1, 20'h0}); else pass_cnt++;
      chk_cnt++; if (obs_addr[obs0+1] !== {10'h2A, 2'd3, 20'h0}) $display("FAIL mid_addr1: got %h expected %h", obs_addr[obs0+1], {10'h2A, 2'd3, 20'h0}); else pass_cnt++;
      chk_cnt++; if (obs_len[obs0+1] !== 8'd127) $display("FAIL mid_len1: got %0d expected 127", obs_len[obs0+1]); else pass_cnt++;
    end
    chk_cnt++; if (wr_total - wr0 !== 384) $display("FAIL mid_writes: got %0d expected 384", wr_total - wr0); else pass_cnt++;
    chk_cnt++; if (done_total - done0 !== 1) $display("FAIL mid_done: got %0d expected 1", done_total - done0); else pass_cnt++;
    chk_cnt++; if (rstlo_total - rst0 !== 1) $display("FAIL mid_fifo_reset: got %0d low cycles expected 1", rstlo_total - rst0); else pass_cnt++;
  endtask

  task automatic test_disable();
    int  obs0, wr0, done0;
    bit  to;
    bit  seen;
    fsize = 32'd4096; idx = 2'd0; base = 10'h1;
    obs0 = obs_n; wr0 = wr_total; done0 = done_total;
    arb_hold = 1'b1;
    send_sof();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_req_o) begin seen = 1'b1; break; end
    end
    chk_cnt++; if (seen !== 1'b1) $display("FAIL dis_req_seen: got 0 expected 1"); else pass_cnt++;
    en = 1'b0;
    tick(5);
    chk_cnt++; if (read_req_o !== 1'b1) $display("FAIL dis_req_held: got %b expected 1", read_req_o); else pass_cnt++;
    arb_hold = 1'b0;
    wait_idle(1000, to);
    chk_cnt++; if (to !== 1'b0) $display("FAIL dis_timeout: busy never dropped"); else pass_cnt++;
    chk_cnt++; if (obs_n - obs0 !== 1) $display("FAIL dis_bursts: got %0d expected 1", obs_n - obs0); else pass_cnt++;
    chk_cnt++; if (wr_total - wr0 !== 256) $display("FAIL dis_writes: got %0d expected 256", wr_total - wr0); else pass_cnt++;
    chk_cnt++; if (done_total - done0 !== 0) $display("FAIL dis_done: got %0d expected 0", done_total - done0); else pass_cnt++;
    tick(30);
    chk_cnt++; if (obs_n - obs0 !== 1) $display("FAIL dis_no_more_req: got %0d expected 1", obs_n - obs0); else pass_cnt++;
    chk_cnt++; if (fifo_reset_o !== 1'b0) $display("FAIL dis_fifo_reset: got %b expected 0", fifo_reset_o); else pass_cnt++;
    en = 1'b1;
    tick(3);
  endtask

  task automatic test_reset_mid_read();
    int  obs0, wr0, done0, req0;
    bit  to;
    fsize = 32'd4096; idx = 2'd2; base = 10'h3;
    send_sof();
    wait_valid(200, to);
    chk_cnt++; if (to !== 1'b0) $display("FAIL rstmid_no_data: no read beat seen"); else pass_cnt++;
    tick(10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (fifo_reset_o !== 1'b0) $display("FAIL rstmid_fifo_reset: got %b expected 0", fifo_reset_o); else pass_cnt++;
    chk_cnt++; if (fifo_write_o !== 1'b0) $display("FAIL rstmid_write: got %b expected 0", fifo_write_o); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_o); else pass_cnt++;
    chk_cnt++; if (read_start_addr_o !== 32'h0) $display("FAIL rstmid_addr: got %h expected 0", read_start_addr_o); else pass_cnt++;
    chk_cnt++; if (read_length_o !== 8'h0) $display("FAIL rstmid_len: got %h expected 0", read_length_o); else pass_cnt++;
    tick(3);
    rst_n = 1'b1;
    obs0 = obs_n; req0 = reqcyc_total;
    tick(40);
    chk_cnt++; if (obs_n - obs0 + reqcyc_total - req0 !== 0) $display("FAIL rstmid_no_req: got %0d requests expected 0", obs_n - obs0); else pass_cnt++;
    chk_cnt++; if (busy_o !== 1'b0) $display("FAIL rstmid_idle: got %b expected 0", busy_o); else pass_cnt++;
    fsize = 32'd512; idx = 2'd1;
    wr0 = wr_total; done0 = done_total;
    send_sof();
    wait_idle(1000, to);
    chk_cnt++; if (wr_total - wr0 !== 64) $display("FAIL rstmid_recover_writes: got %0d expected 64", wr_total - wr0); else pass_cnt++;
    chk_cnt++; if (done_total - done0 !== 1) $display("FAIL rstmid_recover_done: got %0d expected 1", done_total - done0); else pass_cnt++;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_frames();
    test_backpressure();
    test_sof_mid_burst();
    test_disable();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
